// File: rtl/draw_config_ctrl_if.sv
// Host configuration port of draw_config_ctrl: valid/ready shadow writes, commit request,
// and the one-cycle commit result pulses.
interface draw_config_ctrl_if;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [2:0] cfg_addr;
   logic [9:0] cfg_data;
   logic       cfg_commit;
   logic       commit_done;
   logic       commit_err;

   modport master (
      output cfg_valid, cfg_addr, cfg_data, cfg_commit,
      input  cfg_ready, commit_done, commit_err
   );

   modport slave (
      input  cfg_valid, cfg_addr, cfg_data, cfg_commit,
      output cfg_ready, commit_done, commit_err
   );
endinterface

// File: rtl/draw_config_ctrl.sv
// Frame-synchronous configuration controller: host writes a shadow register set, and a
// commit copies it to the active set at the start of vertical blank.
module draw_config_ctrl #(
   parameter int unsigned HMin     = 64,
   parameter int unsigned VMin     = 16,
   parameter int unsigned HActive  = 640,
   parameter int unsigned VActive  = 480,
   parameter int unsigned FrameDiv = 60
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [9:0]          counter_y_i,
   input  logic                auto_en_i,
   draw_config_ctrl_if.slave   cfg,
   output logic [9:0]          box_min_x_o,
   output logic [9:0]          box_max_x_o,
   output logic [9:0]          box_min_y_o,
   output logic [9:0]          box_max_y_o,
   output logic [9:0]          split_x_o,
   output logic [1:0]          mode_o,
   output logic [15:0]         frame_cnt_o
);

   typedef struct packed {
      logic [9:0] min_x;
      logic [9:0] max_x;
      logic [9:0] min_y;
      logic [9:0] max_y;
      logic [9:0] split_x;
      logic [1:0] mode;
   } regs_t;

   typedef enum logic [1:0] {StIdle, StPending, StCommit} state_e;

   localparam regs_t RegsRst = '{
      min_x:   10'(HMin),
      max_x:   10'(HMin + HActive - 1),
      min_y:   10'(VMin),
      max_y:   10'(VMin + VActive - 1),
      split_x: 10'((2 * HMin + HActive - 1) / 2),
      mode:    2'd0
   };
   localparam logic [9:0]  VLast  = 10'(VMin + VActive - 1);
   localparam logic [15:0] DivTop = 16'(FrameDiv);

   state_e      state_q, state_d;
   regs_t       shadow_q, shadow_d;
   regs_t       active_q, active_d;
   logic [9:0]  cy_q;
   logic [15:0] frame_q, frame_d;
   logic [15:0] div_q, div_d;
   logic        ready_q, ready_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        vblank_start;
   logic        shadow_ok;

   assign vblank_start = (cy_q == VLast) && (counter_y_i != cy_q);
   assign shadow_ok    = (shadow_q.min_x <= shadow_q.max_x) && (shadow_q.min_y <= shadow_q.max_y);

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      active_d = active_q;
      frame_d  = frame_q;
      div_d    = div_q;
      done_d   = 1'b0;
      err_d    = 1'b0;

      if (vblank_start) begin
         frame_d = frame_q + 16'd1;
      end

      if (!auto_en_i) begin
         div_d = '0;
      end else if (vblank_start) begin
         if (div_q + 16'd1 >= DivTop) begin
            div_d = '0;
            // A valid commit landing on this vblank overrides the step with the shadow mode.
            if (!(state_q == StPending && shadow_ok)) begin
               active_d.mode = active_q.mode + 2'd1;
            end
         end else begin
            div_d = div_q + 16'd1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (cfg.cfg_valid) begin
               unique case (cfg.cfg_addr)
                  3'd0:    shadow_d.min_x   = cfg.cfg_data;
                  3'd1:    shadow_d.max_x   = cfg.cfg_data;
                  3'd2:    shadow_d.min_y   = cfg.cfg_data;
                  3'd3:    shadow_d.max_y   = cfg.cfg_data;
                  3'd4:    shadow_d.split_x = cfg.cfg_data;
                  3'd5:    shadow_d.mode    = cfg.cfg_data[1:0];
                  default: ;
               endcase
            end
            if (cfg.cfg_commit) begin
               state_d = StPending;
            end
         end
         StPending: begin
            if (vblank_start) begin
               state_d = StCommit;
            end
         end
         StCommit: begin
            if (shadow_ok) begin
               active_d = shadow_q;
               done_d   = 1'b1;
            end else begin
               err_d = 1'b1;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         shadow_q <= RegsRst;
         active_q <= RegsRst;
         cy_q     <= '0;
         frame_q  <= '0;
         div_q    <= '0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         cy_q     <= counter_y_i;
         frame_q  <= frame_d;
         div_q    <= div_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign cfg.cfg_ready   = ready_q;
   assign cfg.commit_done = done_q;
   assign cfg.commit_err  = err_q;

   assign box_min_x_o = active_q.min_x;
   assign box_max_x_o = active_q.max_x;
   assign box_min_y_o = active_q.min_y;
   assign box_max_y_o = active_q.max_y;
   assign split_x_o   = active_q.split_x;
   assign mode_o      = active_q.mode;
   assign frame_cnt_o = frame_q;

endmodule
